// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: BCD digit width and
// active-high segment patterns, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-high output.
// Codes 10..15 are not decimal digits and show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  // Pattern lookup for one digit
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-segment 7-segment display.
// New digit values are staged in a pending register and only copied to the
// displayed register at a frame boundary, so a scan never shows mixed data.
// Build option: define SEG7_LZB_EN for leading-zero blanking of digits >= 1.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_DIGITS*BCD_W-1:0] bcd_in,
  input  logic                        bcd_valid,
  output logic [6:0]                  seg,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        frame_tick
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DW = NUM_DIGITS * BCD_W;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         pending;
  logic [DW-1:0]         disp;
  logic                  pend;
  logic                  tick;
  logic                  frame_end;
  logic [BCD_W-1:0]      cur_digit;
  logic [6:0]            seg_act;
  logic [NUM_DIGITS-1:0] lit;
  logic [NUM_DIGITS-1:0] an_act;

  assign tick      = (presc == PW'(SCAN_DIV - 1));
  assign frame_end = tick && (idx == IW'(NUM_DIGITS - 1));

  // Prescaler and digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      if (idx == IW'(NUM_DIGITS - 1)) idx <= '0;
      else                            idx <= idx + IW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Pending/displayed data; a load coinciding with the boundary skips the
  // pending stage so it is shown in the very next frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      disp    <= '0;
      pend    <= 1'b0;
    end else if (frame_end) begin
      if (bcd_valid)  disp <= bcd_in;
      else if (pend)  disp <= pending;
      pend <= 1'b0;
    end else if (bcd_valid) begin
      pending <= bcd_in;
      pend    <= 1'b1;
    end
  end

  // Select the digit currently being scanned
  always_comb begin
    cur_digit = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) cur_digit = disp[k*BCD_W +: BCD_W];
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (seg_act)
  );

`ifdef SEG7_LZB_EN
  // A digit stays lit if it or any more significant digit is non-zero;
  // digit 0 is always lit
  always_comb begin
    logic higher_nz;
    higher_nz = 1'b0;
    lit       = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      higher_nz |= |disp[(NUM_DIGITS-1-j)*BCD_W +: BCD_W];
      lit[NUM_DIGITS-1-j] = higher_nz || (j == NUM_DIGITS - 1);
    end
  end
`else
  // Every digit is enabled in its slot
  always_comb begin
    lit = '1;
  end
`endif

  // One-hot enable for the scanned digit, gated by blanking
  always_comb begin
    an_act = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      an_act[k] = (idx == IW'(k)) && lit[k];
    end
  end

  // Registered, polarity-adjusted outputs and frame pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg        <= {7{ACTIVE_LOW}} ^ SEG_OFF;
      an         <= {NUM_DIGITS{ACTIVE_LOW}};
      frame_tick <= 1'b0;
    end else begin
      seg        <= {7{ACTIVE_LOW}} ^ seg_act;
      an         <= {NUM_DIGITS{ACTIVE_LOW}} ^ an_act;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, SCAN_DIV=4, active-low).
// Directed frame vectors with hand-derived patterns plus randomized loads and
// resets checked against a cycle-count based reference model.
module tb_seg7_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned FRAME = ND * SD;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   bcd_in;
  logic          bcd_valid;
  logic [6:0]    seg;
  logic [3:0]    an;
  logic          frame_tick;

  int unsigned   checks = 0;
  int unsigned   errors = 0;

  // reference model state: cycles since reset release and data registers
  int unsigned   t;
  logic [15:0]   m_disp;
  logic [15:0]   m_pending;
  bit            m_pend;
  logic          last_ft;

  seg7_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd_in     (bcd_in),
    .bcd_valid  (bcd_valid),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] value;
    bit          has_pre;
    logic [15:0] pre;
    bit          coincident;
    logic [27:0] segs;   // {d3,d2,d1,d0} active-low patterns
    logic [3:0]  blank;  // digits dark under leading-zero blanking
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // One clock: predict from the model, advance it, then compare after the edge
  task automatic step();
    int unsigned slot;
    bit          boundary;
    logic [15:0] upper;
    logic [3:0]  digit;
    bit          lit;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    slot     = (t / SD) % ND;
    boundary = (t % FRAME) == FRAME - 1;
    upper    = m_disp >> (4 * slot);
    digit    = upper[3:0];
`ifdef SEG7_LZB_EN
    lit = (slot == 0) || (upper != 16'h0);
`else
    lit = 1'b1;
`endif
    exp_seg = ~ref_seg(digit);
    exp_an  = lit ? ~(4'b0001 << slot) : 4'hF;
    if (boundary) begin
      if (bcd_valid)   m_disp = bcd_in;
      else if (m_pend) m_disp = m_pending;
      m_pend = 1'b0;
    end else if (bcd_valid) begin
      m_pending = bcd_in;
      m_pend    = 1'b1;
    end
    t++;
    @(posedge clk);
    #1;
    check("model_seg", {25'h0, seg}, {25'h0, exp_seg});
    check("model_an", {28'h0, an}, {28'h0, exp_an});
    check("model_frame_tick", {31'h0, frame_tick}, {31'h0, boundary});
    last_ft = frame_tick;
  endtask

  // Asynchronous reset away from the clock edge; outputs must blank at once
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("reset_seg", {25'h0, seg}, 32'h7F);
    check("reset_an", {28'h0, an}, 32'hF);
    check("reset_frame_tick", {31'h0, frame_tick}, 32'h0);
    t = 0; m_disp = '0; m_pending = '0; m_pend = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step_until_phase(input int unsigned ph);
    for (int i = 0; i < 2 * FRAME && (t % FRAME) != ph; i++) step();
  endtask

  task automatic load_step(input logic [15:0] v);
    bcd_in = v; bcd_valid = 1'b1;
    step();
    bcd_valid = 1'b0; bcd_in = $urandom;
  endtask

  task automatic run_vector(input vec_t v, input int n);
    int  waited;
    step_until_phase(3);
    if (v.has_pre) load_step(v.pre);
    else           step();
    if (v.coincident) begin
      step_until_phase(FRAME - 1);
      load_step(v.value);
    end else begin
      load_step(v.value);
    end
    waited = 0;
    while (!last_ft && waited < 3 * FRAME) begin
      step();
      waited++;
    end
    if (!last_ft) begin
      check("frame_tick_timeout", 32'h0, 32'h1);
      return;
    end
    for (int unsigned d = 0; d < ND; d++) begin
      logic [27:0] segs;
      logic [6:0]  es;
      logic [3:0]  ea;
      segs = v.segs >> (7 * d);
      es   = segs[6:0];
      ea   = ~(4'b0001 << d);
`ifdef SEG7_LZB_EN
      if (v.blank[d]) ea = 4'hF;
`endif
      step();
      check($sformatf("vec%0d_d%0d_seg", n, d), {25'h0, seg}, {25'h0, es});
      check($sformatf("vec%0d_d%0d_an", n, d), {28'h0, an}, {28'h0, ea});
      for (int unsigned c = 1; c < SD; c++) step();
    end
  endtask

  initial begin
    vecs[0] = '{value: 16'h1234, has_pre: 0, pre: 16'h0,    coincident: 0,
                segs: {7'h79, 7'h24, 7'h30, 7'h19}, blank: 4'b0000};
    vecs[1] = '{value: 16'h5678, has_pre: 1, pre: 16'h1111, coincident: 0,
                segs: {7'h12, 7'h02, 7'h78, 7'h00}, blank: 4'b0000};
    vecs[2] = '{value: 16'h0009, has_pre: 1, pre: 16'h7777, coincident: 1,
                segs: {7'h40, 7'h40, 7'h40, 7'h10}, blank: 4'b1110};
    vecs[3] = '{value: 16'hA0F3, has_pre: 0, pre: 16'h0,    coincident: 0,
                segs: {7'h3F, 7'h40, 7'h3F, 7'h30}, blank: 4'b0000};
    vecs[4] = '{value: 16'h0042, has_pre: 0, pre: 16'h0,    coincident: 0,
                segs: {7'h40, 7'h40, 7'h19, 7'h24}, blank: 4'b1100};
    vecs[5] = '{value: 16'h0000, has_pre: 0, pre: 16'h0,    coincident: 0,
                segs: {7'h40, 7'h40, 7'h40, 7'h40}, blank: 4'b1110};

    reset = 1'b1; bcd_valid = 1'b0; bcd_in = '0; last_ft = 1'b0;
    t = 0; m_disp = '0; m_pending = '0; m_pend = 1'b0;
    #2;
    check("por_seg", {25'h0, seg}, 32'h7F);
    check("por_an", {28'h0, an}, 32'hF);
    check("por_frame_tick", {31'h0, frame_tick}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // first clock after release: digit 0 showing "0"
    step();
    check("first_an", {28'h0, an}, 32'hE);
    check("first_seg", {25'h0, seg}, 32'h40);

    // pending data loaded mid-frame is discarded by a reset
    for (int i = 0; i < 20; i++) step();
    step_until_phase(6);
    load_step(16'h4321);
    for (int i = 0; i < 3; i++) step();
    do_reset();
    step();
    check("post_reset_an", {28'h0, an}, 32'hE);
    check("post_reset_seg", {25'h0, seg}, 32'h40);
    for (int i = 0; i < 2 * FRAME; i++) step();

    // directed frame vectors
    for (int n = 0; n < 6; n++) run_vector(vecs[n], n);
    for (int i = 0; i < FRAME; i++) step();

    // randomized loads with occasional mid-frame resets
    for (int i = 0; i < 600; i++) begin
      if (i == 200 || i == 417) do_reset();
      bcd_in    = $urandom;
      bcd_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) bcd_in = bcd_in & 16'h00FF;
      step();
    end
    bcd_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream display stage for the decade counters. It accepts NUM_DIGITS BCD digits, for example the 4-bit count of one or more cascaded mod-10 counters. It time-multiplexes them onto a single common-segment 7-segment display. Display updates are frame-synchronous, so a digit never tears mid-scan.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8); digit 0 is least significant and rightmost.
SCAN_DIV, 50000, clk cycles each digit stays enabled (>=1).
ACTIVE_LOW, 1, 1: seg and an are driven low-true; 0: high-true.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-high reset.
bcd_in  input  4*NUM_DIGITS  digit k occupies bits [4k+3:4k].
bcd_valid  input  1  load strobe; samples bcd_in this cycle.
seg  output  7  {g,f,e,d,c,b,a}, registered.
an  output  NUM_DIGITS  digit enables, one-hot when active, registered.
frame_tick  output  1  one-cycle pulse at each frame boundary, registered.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Prescaler presc counts 0..SCAN_DIV-1. A tick occurs when presc==SCAN_DIV-1, and presc then wraps to 0. With SCAN_DIV=1, a tick occurs every cycle.
- Digit index idx counts 0..NUM_DIGITS-1 and advances on each tick. It wraps from NUM_DIGITS-1 to 0.
- A frame boundary is a tick with idx==NUM_DIGITS-1. frame_tick is high for exactly the cycle after the boundary.
- Load:
  - bcd_valid=1 copies bcd_in into the pending register and sets pend. If several loads arrive within one frame, the last one wins.
  - At a frame boundary with pend=1, disp is loaded from pending and pend clears.
  - If bcd_valid coincides with a boundary, bcd_in bypasses straight into disp at that edge and pend is left 0.
  - disp changes only at frame boundaries.
- Output: seg and an are registered from the current idx and disp, with 1-cycle latency.
  - an enables bit idx only.
  - seg is decode(disp digit idx).
- Decode (active-high values): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F.
  - Codes 10..15 show a dash, 40.
  - With ACTIVE_LOW=1, seg and an are the bitwise inverse.
- Reset values: presc=0, idx=0, pending=0, disp=0, pend=0, frame_tick=0.
  - seg and an are all off: seg=7F, an=all 1s when ACTIVE_LOW=1.
  - The first clock after reset release shows digit 0 with value 0.
- Reset mid-frame immediately blanks the outputs and discards pending data.

Optional Feature:
SEG7_LZB_EN, leading-zero blanking.
- Defined: digit k (k>=1) has its an bit forced off when disp digit k and all higher digits are 0. Digit 0 is never blanked, so 0000 shows "0".
- Undefined: all digits are always enabled in turn.
- Scan timing is identical in both builds.

Decomposition:
- Package seg7_pkg holds:
  - segment-pattern localparams SEG_0..SEG_9, SEG_DASH and SEG_OFF (active-high, 7 bits);
  - the digit-width constant BCD_W=4.
- Sub-module bcd_to_seg7: purely combinational 4-bit to 7-bit decoder, instanced once on the muxed digit. Polarity inversion stays in the top level.
- The top level contains the prescaler, idx, the pending/disp registers, blanking logic and output registers.

Test Plan:
1. Reset (NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1): assert reset mid-run -> seg=7F, an=F immediately. One clock after release -> an=E, seg=40 (digit 0 = "0").
2. Load bcd_in=16'h1234 mid-frame -> display unchanged until the next frame_tick. Then every 4 cycles: an=E seg=19, an=D seg=30, an=B seg=24, an=7 seg=79, repeating.
3. Two loads in one frame, 16'h1111 then 16'h5678 -> next frame shows only 5678. Digit 0 seg=00 (inverse of 7F).
4. bcd_valid coincident with the frame boundary, 16'h0009 -> applied at that boundary: digit 0 seg=10, and pend is not left set.
5. Invalid code, bcd_in=16'hA0F3 -> digits 3 and 1 show seg=3F (dash), digit 0 shows seg=30, digit 2 shows seg=40.
6. With SEG7_LZB_EN, load 16'h0042 -> an never asserts for digits 3 and 2. Load 16'h0000 -> only digit 0 is enabled, seg=40.
